siren_sequencer: RTL and testbench
==================================

SIREN_SEQUENCER -- requirements
Module: siren_sequencer

Interface
REQ-001 The block SHALL have parameter W, default 16, width of half-period, step and cur_half values in clk cycles.
REQ-002 The block SHALL have parameter DW, default 24, width of the dwell count in clk cycles.
REQ-003 The block SHALL have port clk  input  1  system clock (27 MHz); the only clock, all logic on posedge clk.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port on  input  1  run enable; 0 silences and idles the block.
REQ-006 The block SHALL have port mode  input  2  00 ALT two-tone, 01 WAIL up/down sweep, 10 YELP one-way sweep, 11 STEADY tone.
REQ-007 The block SHALL have port half_lo  input  W  half-period of the highest pitch.
REQ-008 The block SHALL have port half_hi  input  W  half-period of the lowest pitch.
REQ-009 The block SHALL have port step  input  W  half-period change per dwell interval (WAIL/YELP).
REQ-010 The block SHALL have port dwell  input  DW  clk cycles per tone (ALT) or per sweep step (WAIL/YELP).
REQ-011 The block SHALL have port speaker  output  1  registered square-wave audio output.
REQ-012 The block SHALL have port cur_half  output  W  half-period currently in use.
REQ-013 The block SHALL have port step_pulse  output  1  one-cycle strobe at every dwell boundary.
REQ-014 The block SHALL have port dir  output  1  WAIL sweep direction: 0 = falling half-period (rising pitch), 1 = rising half-period.

Function
REQ-015 The block SHALL use no derived clocks; all counting SHALL be clock-enable based on clk.
REQ-016 Effective values SHALL be computed every cycle: lo = min(half_lo, half_hi), hi = max(half_lo, half_hi); a value of 0 for lo, hi or dwell SHALL be treated as 1.
REQ-017 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-018 In IDLE, speaker, step_pulse and all counters SHALL be 0, and cur_half SHALL hold its value.
REQ-019 In IDLE with on=1, the block SHALL load cur_half with the start value, hi for ALT/WAIL/YELP and lo for STEADY, clear dir, and enter RUN at the same edge.
REQ-020 In RUN, hp_cnt SHALL increment each cycle; when hp_cnt >= cur_half-1, speaker SHALL toggle and hp_cnt SHALL clear.
- Result: the first speaker rise occurs cur_half edges after RUN entry, with period 2*cur_half.
REQ-021 In RUN, dw_cnt SHALL increment each cycle; when dw_cnt == dwell-1, dw_cnt SHALL clear, step_pulse SHALL be 1 for the following cycle, and cur_half SHALL update at that edge per REQ-022..025.
REQ-022 ALT update: cur_half SHALL alternate hi -> lo -> hi.
REQ-023 WAIL update:
- dir=0: cur_half <= cur_half-step, saturating at lo; on reaching lo, dir <= 1.
- dir=1: cur_half <= cur_half+step, saturating at hi; on reaching hi, dir <= 0.
REQ-024 YELP update: cur_half <= cur_half-step saturating at lo; a step taken while cur_half == lo SHALL reload hi.
REQ-025 STEADY update: cur_half SHALL stay at lo; step_pulse SHALL still strobe.
REQ-026 step = 0 in WAIL/YELP SHALL leave cur_half unchanged, with no direction change or reload.
REQ-027 Tone changes SHALL be phase-continuous: hp_cnt is not cleared at a step; the >= compare of REQ-020 handles a shortened half-period.
REQ-028 In RUN with on=0, the block SHALL go to IDLE at the next edge, with speaker 0 at that edge.
REQ-029 In RUN, a change of mode from its previous-cycle value SHALL restart the sequence at that edge: clear counters, speaker 0, load the start value of the new mode, dir 0; the block stays in RUN.
REQ-030 Changes to half_lo, half_hi, step and dwell SHALL take effect at the next compare or step, with no restart.

Reset
REQ-031 With reset=1 at an edge, the block SHALL set state IDLE, speaker 0, step_pulse 0, dir 0, cur_half 0, and all counters 0, overriding all other inputs including mid-operation.
REQ-032 After reset is released, the block SHALL remain in IDLE until on=1 is sampled.

Verification
REQ-033 ALT: W=8, lo=3, hi=5, dwell=20, on=1 -> cur_half=5 with speaker period 10 for 20 cycles; step_pulse; cur_half=3 with period 6; alternation repeats.
REQ-034 WAIL: lo=2, hi=6, step=2, dwell=4 -> cur_half sequence 6,4,2,4,6,4,2, each held 4 cycles; dir toggles at 2 and at 6.
REQ-035 YELP: lo=2, hi=6, step=3, dwell=4 -> cur_half sequence 6,3,2,6,3,2 (3-3 saturates to 2).
REQ-036 on dropped mid-tone in WAIL with cur_half=4 -> speaker 0 at the next edge and IDLE; on reasserted -> cur_half=6 and dir=0, first speaker rise 6 edges later.
REQ-037 Zero/swap: half_lo=0, half_hi=0, dwell=0, mode STEADY -> speaker toggles every cycle and step_pulse is high every cycle after the first; half_lo=9, half_hi=4 in ALT -> start cur_half=9.
REQ-038 Reset and mode change: reset asserted mid-RUN -> all outputs 0 at the next edge; mode switched ALT->WAIL mid-tone -> counters clear, speaker 0, cur_half=hi.

Source files
------------

// File: rtl/siren_sequencer_if.sv
// Control and audio signals of the siren sequencer, bundled for the master
// (controller) and slave (sequencer) sides.
interface siren_sequencer_if #(
  parameter int W  = 16,
  parameter int DW = 24
);
  logic          on;
  logic [1:0]    mode;
  logic [W-1:0]  half_lo;
  logic [W-1:0]  half_hi;
  logic [W-1:0]  step;
  logic [DW-1:0] dwell;
  logic          speaker;
  logic [W-1:0]  cur_half;
  logic          step_pulse;
  logic          dir;

  modport master (
    output on, mode, half_lo, half_hi, step, dwell,
    input  speaker, cur_half, step_pulse, dir
  );

  modport slave (
    input  on, mode, half_lo, half_hi, step, dwell,
    output speaker, cur_half, step_pulse, dir
  );
endinterface

// File: rtl/siren_sequencer.sv
// Siren tone sequencer: square-wave generator whose half-period is stepped
// every dwell interval according to ALT / WAIL / YELP / STEADY patterns.
module siren_sequencer #(
  parameter int W  = 16,
  parameter int DW = 24
) (
  input logic              clk,
  input logic              reset,
  siren_sequencer_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_e;
  typedef enum logic [1:0] {ALT = 2'b00, WAIL = 2'b01, YELP = 2'b10, STEADY = 2'b11} mode_e;

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic          speaker_q, speaker_d;
  logic [W-1:0]  cur_half_q, cur_half_d;
  logic          step_pulse_q, step_pulse_d;
  logic          dir_q, dir_d;
  logic [W-1:0]  hp_cnt_q, hp_cnt_d;
  logic [DW-1:0] dw_cnt_q, dw_cnt_d;

  logic [W-1:0]  lo, hi, start_half, next_half;
  logic [DW-1:0] dwell_eff;
  logic          next_dir;
  logic [W:0]    cur_x, step_x, lo_x, hi_x;

  always_comb begin
    lo = (bus.half_lo < bus.half_hi) ? bus.half_lo : bus.half_hi;
    hi = (bus.half_lo < bus.half_hi) ? bus.half_hi : bus.half_lo;
    if (lo == '0) lo = W'(1);
    if (hi == '0) hi = W'(1);
    dwell_eff = (bus.dwell == '0) ? DW'(1) : bus.dwell;
    start_half = (mode_e'(bus.mode) == STEADY) ? lo : hi;
  end

  // Sweep arithmetic is done one bit wider so cur-step / cur+step cannot wrap.
  always_comb begin
    cur_x     = {1'b0, cur_half_q};
    step_x    = {1'b0, bus.step};
    lo_x      = {1'b0, lo};
    hi_x      = {1'b0, hi};
    next_half = cur_half_q;
    next_dir  = dir_q;
    case (mode_e'(bus.mode))
      ALT: next_half = (cur_half_q == hi) ? lo : hi;
      WAIL: begin
        if (bus.step != '0) begin
          if (!dir_q) begin
            if (cur_x <= lo_x + step_x) begin
              next_half = lo;
              next_dir  = 1'b1;
            end else begin
              next_half = cur_half_q - bus.step;
            end
          end else begin
            if (cur_x + step_x >= hi_x) begin
              next_half = hi;
              next_dir  = 1'b0;
            end else begin
              next_half = cur_half_q + bus.step;
            end
          end
        end
      end
      YELP: begin
        if (bus.step != '0) begin
          if (cur_half_q <= lo)                next_half = hi;
          else if (cur_x <= lo_x + step_x)     next_half = lo;
          else                                 next_half = cur_half_q - bus.step;
        end
      end
      default: next_half = lo;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = bus.mode;
    speaker_d    = speaker_q;
    cur_half_d   = cur_half_q;
    step_pulse_d = 1'b0;
    dir_d        = dir_q;
    hp_cnt_d     = hp_cnt_q;
    dw_cnt_d     = dw_cnt_q;
    case (state_q)
      IDLE: begin
        speaker_d = 1'b0;
        hp_cnt_d  = '0;
        dw_cnt_d  = '0;
        if (bus.on) begin
          state_d    = RUN;
          cur_half_d = start_half;
          dir_d      = 1'b0;
        end
      end
      RUN: begin
        if (!bus.on) begin
          state_d   = IDLE;
          speaker_d = 1'b0;
          hp_cnt_d  = '0;
          dw_cnt_d  = '0;
        end else if (bus.mode != mode_q) begin
          speaker_d  = 1'b0;
          hp_cnt_d   = '0;
          dw_cnt_d   = '0;
          cur_half_d = start_half;
          dir_d      = 1'b0;
        end else begin
          // hp_cnt is never cleared at a step; >= absorbs a shortened half-period.
          if ({1'b0, hp_cnt_q} + (W+1)'(1) >= cur_x) begin
            speaker_d = ~speaker_q;
            hp_cnt_d  = '0;
          end else begin
            hp_cnt_d  = hp_cnt_q + W'(1);
          end
          if (dw_cnt_q >= dwell_eff - DW'(1)) begin
            dw_cnt_d     = '0;
            step_pulse_d = 1'b1;
            cur_half_d   = next_half;
            dir_d        = next_dir;
          end else begin
            dw_cnt_d     = dw_cnt_q + DW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= '0;
      speaker_q    <= 1'b0;
      cur_half_q   <= '0;
      step_pulse_q <= 1'b0;
      dir_q        <= 1'b0;
      hp_cnt_q     <= '0;
      dw_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      speaker_q    <= speaker_d;
      cur_half_q   <= cur_half_d;
      step_pulse_q <= step_pulse_d;
      dir_q        <= dir_d;
      hp_cnt_q     <= hp_cnt_d;
      dw_cnt_q     <= dw_cnt_d;
    end
  end

  assign bus.speaker    = speaker_q;
  assign bus.cur_half   = cur_half_q;
  assign bus.step_pulse = step_pulse_q;
  assign bus.dir        = dir_q;

endmodule

// File: tb/tb_siren_sequencer.sv
// Scoreboard bench for siren_sequencer: a reference model queues the expected
// outputs of every edge, a monitor compares them on the falling edge.
module tb_siren_sequencer;
  localparam int W  = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;

  siren_sequencer_if #(.W(W), .DW(DW)) bus ();

  siren_sequencer #(.W(W), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit spk;
    int cur;
    bit pulse;
    bit dir;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  int wail_cur[7] = '{6, 4, 2, 4, 6, 4, 2};
  bit wail_dir[7] = '{0, 0, 1, 1, 0, 0, 1};
  int yelp_cur[7] = '{6, 3, 2, 6, 3, 2, 6};
  bit yelp_dir[7] = '{0, 0, 0, 0, 0, 0, 0};

  // Reference model state: running flag, cycles since last speaker toggle,
  // cycles into the current dwell, current pitch (half-period), sweep direction.
  bit m_run, m_spk, m_pulse, m_up;
  int m_phase, m_tick, m_pitch, m_prev;

  always @(posedge clk) begin : ref_model
    int a, b, lo, hi, dw, st, md, start;
    exp_t e;
    a  = int'(bus.half_lo);
    b  = int'(bus.half_hi);
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    if (lo == 0) lo = 1;
    if (hi == 0) hi = 1;
    dw = (int'(bus.dwell) == 0) ? 1 : int'(bus.dwell);
    st = int'(bus.step);
    md = int'(bus.mode);
    start = (md == 3) ? lo : hi;
    if (reset) begin
      m_run = 0; m_spk = 0; m_pulse = 0; m_up = 0;
      m_phase = 0; m_tick = 0; m_pitch = 0;
    end else if (!m_run) begin
      m_spk = 0; m_pulse = 0; m_phase = 0; m_tick = 0;
      if (bus.on) begin
        m_run = 1; m_pitch = start; m_up = 0;
      end
    end else if (!bus.on) begin
      m_run = 0; m_spk = 0; m_pulse = 0; m_phase = 0; m_tick = 0;
    end else if (md != m_prev) begin
      m_spk = 0; m_pulse = 0; m_phase = 0; m_tick = 0; m_pitch = start; m_up = 0;
    end else begin
      m_phase = m_phase + 1;
      if (m_phase >= m_pitch) begin
        m_spk = ~m_spk;
        m_phase = 0;
      end
      m_tick = m_tick + 1;
      m_pulse = (m_tick >= dw);
      if (m_pulse) begin
        m_tick = 0;
        case (md)
          0: m_pitch = (m_pitch == hi) ? lo : hi;
          1: if (st != 0) begin
               if (!m_up) begin
                 m_pitch = m_pitch - st;
                 if (m_pitch <= lo) begin m_pitch = lo; m_up = 1; end
               end else begin
                 m_pitch = m_pitch + st;
                 if (m_pitch >= hi) begin m_pitch = hi; m_up = 0; end
               end
             end
          2: if (st != 0) begin
               if (m_pitch <= lo) m_pitch = hi;
               else begin
                 m_pitch = m_pitch - st;
                 if (m_pitch < lo) m_pitch = lo;
               end
             end
          default: m_pitch = lo;
        endcase
      end
    end
    m_prev = reset ? 0 : md;
    e.spk = m_spk; e.cur = m_pitch; e.pulse = m_pulse; e.dir = m_up;
    sb_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [W-1:0] ec;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard t=%0t: no expected entry queued, required one per edge", $time);
    end else begin
      e  = sb_q.pop_front();
      ec = W'(e.cur);
      if (bus.speaker !== e.spk || bus.cur_half !== ec ||
          bus.step_pulse !== e.pulse || bus.dir !== e.dir) begin
        miscompares++;
        $display("FAIL outputs t=%0t: speaker=%0b cur_half=%0d step_pulse=%0b dir=%0b, required speaker=%0b cur_half=%0d step_pulse=%0b dir=%0b",
                 $time, bus.speaker, bus.cur_half, bus.step_pulse, bus.dir,
                 e.spk, e.cur, e.pulse, e.dir);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // Samples cur_half (and optionally dir) once per 4-cycle dwell, starting
  // just after the edge that enters or restarts the sequence.
  task automatic check_seq(input string name, input int exp_cur[7],
                           input bit exp_dir[7], input bit chk_dir, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ((k == 0) ? 1 : 4) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.cur_half !== W'(exp_cur[k]) || (chk_dir && bus.dir !== exp_dir[k])) begin
        miscompares++;
        $display("FAIL %s step %0d: cur_half=%0d dir=%0b, required cur_half=%0d dir=%0b",
                 name, k, bus.cur_half, bus.dir, exp_cur[k], exp_dir[k]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.on = 1'b0; bus.mode = 2'b00;
    bus.half_lo = '0; bus.half_hi = '0; bus.step = '0; bus.dwell = '0;
    cyc(3);
    reset = 1'b0;
    cyc(4);

    bus.half_lo = 8'd3; bus.half_hi = 8'd5; bus.dwell = 8'd20; bus.mode = 2'b00; bus.on = 1'b1;
    cyc(70);
    bus.on = 1'b0;
    cyc(2);

    bus.half_lo = 8'd2; bus.half_hi = 8'd6; bus.step = 8'd2; bus.dwell = 8'd4;
    bus.mode = 2'b01; bus.on = 1'b1;
    check_seq("wail_seq", wail_cur, wail_dir, 1'b1, 7);
    cyc(6);
    bus.on = 1'b0;
    cyc(3);
    bus.on = 1'b1;
    cyc(20);

    bus.step = 8'd3; bus.mode = 2'b10;
    check_seq("yelp_seq", yelp_cur, yelp_dir, 1'b0, 7);
    cyc(5);

    bus.half_lo = '0; bus.half_hi = '0; bus.dwell = '0; bus.mode = 2'b11;
    cyc(12);

    bus.half_lo = 8'd9; bus.half_hi = 8'd4; bus.dwell = 8'd6; bus.mode = 2'b00;
    cyc(30);
    bus.step = 8'd1; bus.mode = 2'b01;
    cyc(25);

    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(10);

    for (int i = 0; i < 2500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      reset = (r < 2);
      if (r >= 2 && r < 5) bus.on = ~bus.on;
      if (r >= 5 && r < 9) bus.mode = 2'($urandom_range(0, 3));
      if (r >= 9 && r < 13) begin
        bus.half_lo = 8'($urandom_range(0, 15));
        bus.half_hi = 8'($urandom_range(0, 15));
        bus.step    = 8'($urandom_range(0, 5));
        bus.dwell   = 8'($urandom_range(0, 8));
      end
      if (r >= 95) bus.on = 1'b1;
      cyc(1);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
